// File: rtl/uart_rx_8bit.sv
// 8N1 UART receiver feeding Registro8bits: DATA -> D, VALID -> ENA.
// Two-flop synchronized RX, mid-bit sampling, framing error with break hold-off.
module uart_rx_8bit #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       BUSY,
    output logic       FRAME_ERR
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state, state_n;

    logic          rx_m, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bidx, bidx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          valid_n, ferr_n;

    // Synchronizer resets to the idle line level so reset never fakes a start bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bidx      <= '0;
            shift     <= '0;
            DATA      <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bidx      <= bidx_n;
            shift     <= shift_n;
            DATA      <= data_n;
            VALID     <= valid_n;
            FRAME_ERR <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bidx_n  = bidx;
        shift_n = shift;
        data_n  = DATA;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                cnt_n = cnt + CW'(1);
                if (cnt == HALF) begin
                    cnt_n  = '0;
                    bidx_n = '0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                cnt_n = cnt + CW'(1);
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    if (bidx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bidx_n = bidx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                cnt_n = cnt + CW'(1);
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8bit.sv
// Directed bench for uart_rx_8bit at 16 clocks per bit.
// Hand-timed frames, glitch, framing error and mid-frame reset.
module tb_uart_rx_8bit;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX  = 1'b1;
    logic [7:0] DATA;
    logic       VALID;
    logic       BUSY;
    logic       FRAME_ERR;

    uart_rx_8bit #(.CLKS_PER_BIT(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX       (RX),
        .DATA     (DATA),
        .VALID    (VALID),
        .BUSY     (BUSY),
        .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0;
    int n;
    int nf;

    int         vt[$];
    logic [7:0] vd[$];
    logic [1:0] vb[$];
    int         ft[$];
    logic       prev_busy = 1'b0;
    logic [7:0] q8 = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Downstream Registro8bits model.
    always @(posedge CLK) begin
        if (RST) q8 <= 8'h00;
        else if (VALID) q8 <= DATA;
    end

    always @(negedge CLK) begin
        if (VALID) begin
            vt.push_back(cyc + 1);
            vd.push_back(DATA);
            vb.push_back({prev_busy, BUSY});
        end
        if (FRAME_ERR) ft.push_back(cyc + 1);
        if (VALID || FRAME_ERR) chk("valid_ferr_excl", {31'd0, VALID & FRAME_ERR}, 32'd0);
        prev_busy = BUSY;
    end

    task automatic bit_out(input logic v);
        #1 RX = v;
        repeat (16) @(posedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, output int start);
        #1 RX = 1'b0;
        start = cyc + 1;
        repeat (16) @(posedge CLK);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
    endtask

    task automatic idle(input int c);
        #1 RX = 1'b1;
        repeat (c) @(posedge CLK);
    endtask

    int s1, s2, s3;

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_data", {24'd0, DATA}, 32'h00);
        chk("rst_valid", {31'd0, VALID}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_ferr", {31'd0, FRAME_ERR}, 32'd0);
        RST = 1'b0;
        repeat (5) @(posedge CLK);

        // Single frame A5
        n = vt.size();
        send_byte(8'hA5, 1'b1, t0);
        idle(30);
        chk("a5_count", vt.size() - n, 32'd1);
        if (vt.size() > n) begin
            chk("a5_edge", vt[n] - t0, 32'd155);
            chk("a5_data", {24'd0, vd[n]}, 32'hA5);
            chk("a5_busy_fall", {30'd0, vb[n]}, 32'd2);
        end
        chk("a5_ferr", ft.size(), 32'd0);
        chk("a5_reg", {24'd0, q8}, 32'hA5);

        // Back-to-back 00, FF, 3C
        n = vt.size();
        send_byte(8'h00, 1'b1, s1);
        send_byte(8'hFF, 1'b1, s2);
        send_byte(8'h3C, 1'b1, s3);
        idle(30);
        chk("b2b_count", vt.size() - n, 32'd3);
        if (vt.size() >= n + 3) begin
            chk("b2b_edge0", vt[n] - s1, 32'd155);
            chk("b2b_gap1", vt[n+1] - vt[n], 32'd160);
            chk("b2b_gap2", vt[n+2] - vt[n+1], 32'd160);
            chk("b2b_d0", {24'd0, vd[n]}, 32'h00);
            chk("b2b_d1", {24'd0, vd[n+1]}, 32'hFF);
            chk("b2b_d2", {24'd0, vd[n+2]}, 32'h3C);
        end
        chk("b2b_ferr", ft.size(), 32'd0);

        // 5-cycle low glitch
        n = vt.size();
        #1 RX = 1'b0;
        repeat (5) @(posedge CLK);
        #1 RX = 1'b1;
        @(negedge CLK);
        chk("glitch_busy_hi", {31'd0, BUSY}, 32'd1);
        repeat (12) @(posedge CLK);
        @(negedge CLK);
        chk("glitch_busy_lo", {31'd0, BUSY}, 32'd0);
        repeat (150) @(posedge CLK);
        chk("glitch_valid", vt.size() - n, 32'd0);
        chk("glitch_ferr", ft.size(), 32'd0);
        chk("glitch_data", {24'd0, DATA}, 32'h3C);

        // 55 with low stop bit, then line held low
        n = vt.size();
        send_byte(8'h55, 1'b0, t0);
        repeat (40) @(posedge CLK);
        @(negedge CLK);
        chk("ferr_count", ft.size(), 32'd1);
        if (ft.size() > 0) chk("ferr_edge", ft[0] - t0, 32'd155);
        chk("ferr_valid", vt.size() - n, 32'd0);
        chk("ferr_data", {24'd0, DATA}, 32'h3C);
        chk("ferr_busy_hold", {31'd0, BUSY}, 32'd1);
        idle(4);
        @(negedge CLK);
        chk("ferr_busy_rel", {31'd0, BUSY}, 32'd0);
        idle(10);
        send_byte(8'h81, 1'b1, t0);
        idle(30);
        chk("r81_count", vt.size() - n, 32'd1);
        if (vt.size() > n) begin
            chk("r81_edge", vt[n] - t0, 32'd155);
            chk("r81_data", {24'd0, vd[n]}, 32'h81);
        end
        chk("r81_ferr", ft.size(), 32'd1);

        // Reset during data bit 4 of F0
        n = vt.size();
        nf = ft.size();
        #1 RX = 1'b0;
        repeat (16) @(posedge CLK);
        for (int i = 0; i < 4; i++) bit_out(1'b0);
        #1 RX = 1'b1;
        repeat (8) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("mrst_data", {24'd0, DATA}, 32'h00);
        chk("mrst_valid", {31'd0, VALID}, 32'd0);
        chk("mrst_busy", {31'd0, BUSY}, 32'd0);
        chk("mrst_ferr", {31'd0, FRAME_ERR}, 32'd0);
        repeat (80) @(posedge CLK);
        chk("mrst_novalid", vt.size() - n, 32'd0);
        send_byte(8'h7E, 1'b1, t0);
        idle(30);
        chk("r7e_count", vt.size() - n, 32'd1);
        if (vt.size() > n) chk("r7e_data", {24'd0, vd[n]}, 32'h7E);
        chk("r7e_out", {24'd0, DATA}, 32'h7E);
        chk("r7e_reg", {24'd0, q8}, 32'h7E);
        chk("r7e_ferr", ft.size() - nf, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
